// File: rtl/matvec_sequencer.sv
// Matrix-by-vector sequencer: fetches one row per pass, drives an external inner-product
// datapath from registers and streams DW-bit results. Optional abort port: MATVEC_ABORT_EN.
`timescale 1ns/1ps
module matvec_sequencer #(
  parameter int N  = 4,
  parameter int M  = 4,
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [DW*N-1:0] vec_in,
  output logic            row_req,
  output logic [AW-1:0]   row_addr,
  input  logic            row_valid,
  input  logic [DW*N-1:0] row_data,
  output logic [DW*N-1:0] ip_inp1,
  output logic [DW*N-1:0] ip_inp2,
  input  logic [DW-1:0]   ip_outp,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [DW-1:0]   res_data,
  output logic [AW-1:0]   res_idx,
  output logic            busy,
`ifdef MATVEC_ABORT_EN
  input  logic            abort,
`endif
  output logic            done
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_CALC, S_OUT, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     row_q, row_d;
  logic [DW*N-1:0]   row_reg_q, row_reg_d;
  logic [DW*N-1:0]   vec_q, vec_d;
  logic [DW-1:0]     res_data_q, res_data_d;
  logic [AW-1:0]     res_idx_q, res_idx_d;
  logic              abort_w;

`ifdef MATVEC_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // NOTE: reset is synchronous, so it is tested inside the clocked block rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      row_reg_q  <= '0;
      vec_q      <= '0;
      res_data_q <= '0;
      res_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      row_reg_q  <= row_reg_d;
      vec_q      <= vec_d;
      res_data_q <= res_data_d;
      res_idx_q  <= res_idx_d;
    end
  end

  // NOTE: every next-state signal starts from its current value so no path leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    row_reg_d  = row_reg_q;
    vec_d      = vec_q;
    res_data_d = res_data_q;
    res_idx_d  = res_idx_q;

    if (abort_w && (state_q == S_FETCH || state_q == S_CALC || state_q == S_OUT)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            vec_d   = vec_in;
            row_d   = '0;
            state_d = S_FETCH;
          end
        end
        S_FETCH: begin
          if (row_valid) begin
            row_reg_d = row_data;
            state_d   = S_CALC;
          end
        end
        S_CALC: begin
          res_data_d = ip_outp;
          res_idx_d  = row_q;
          state_d    = S_OUT;
        end
        S_OUT: begin
          if (res_ready) begin
            if (row_q == AW'(M - 1)) begin
              state_d = S_DONE;
            end else begin
              row_d   = row_q + AW'(1);
              state_d = S_FETCH;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign row_req   = (state_q == S_FETCH);
  assign row_addr  = row_q;
  assign ip_inp1   = row_reg_q;
  assign ip_inp2   = vec_q;
  assign res_valid = (state_q == S_OUT);
  assign res_data  = res_data_q;
  assign res_idx   = res_idx_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_matvec_sequencer.sv
// Scoreboard bench for matvec_sequencer with a behavioural inner-product datapath and row memory.
`timescale 1ns/1ps
module tb_matvec_sequencer;
  localparam int N  = 4;
  localparam int M  = 2;
  localparam int DW = 8;
  localparam int AW = 2;
  localparam int VW = DW * N;

  logic          clk = 1'b0;
  logic          rst, start, row_valid, res_ready;
  logic [VW-1:0] vec_in, row_data, ip_inp1, ip_inp2;
  logic          row_req, res_valid, busy, done;
  logic [AW-1:0] row_addr, res_idx;
  logic [DW-1:0] ip_outp, res_data;
`ifdef MATVEC_ABORT_EN
  logic          abort;
`endif

  logic [VW-1:0] mem [2**AW];

  typedef struct packed {
    logic [AW-1:0] idx;
    logic [DW-1:0] data;
  } res_t;

  res_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  matvec_sequencer #(.N(N), .M(M), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .vec_in(vec_in),
    .row_req(row_req), .row_addr(row_addr), .row_valid(row_valid), .row_data(row_data),
    .ip_inp1(ip_inp1), .ip_inp2(ip_inp2), .ip_outp(ip_outp),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_idx(res_idx),
    .busy(busy),
`ifdef MATVEC_ABORT_EN
    .abort(abort),
`endif
    .done(done)
  );

  function automatic logic [VW-1:0] pack4(input int a, input int b, input int c, input int d);
    return {DW'(d), DW'(c), DW'(b), DW'(a)};
  endfunction

  function automatic logic [DW-1:0] dot(input logic [VW-1:0] a, input logic [VW-1:0] b);
    logic [DW-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) s = s + DW'(a[i*DW +: DW] * b[i*DW +: DW]);
    return s;
  endfunction

  // Inner-product datapath and row memory sitting next to the sequencer.
  assign ip_outp  = dot(ip_inp1, ip_inp2);
  assign row_data = mem[row_addr];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int idx, input int data);
    res_t e;
    e.idx  = AW'(idx);
    e.data = DW'(data);
    exp_q.push_back(e);
  endtask

  task automatic push_model(input logic [VW-1:0] v);
    for (int r = 0; r < M; r++) push_exp(r, int'(dot(mem[r], v)));
  endtask

  task automatic start_op(input logic [VW-1:0] v);
    @(posedge clk); #1;
    vec_in = v;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  // Waits for the done pulse; exp_lat <= 0 skips the latency comparison.
  task automatic wait_done(input int exp_lat);
    int n;
    bit seen;
    seen = 1'b0;
    for (n = 1; n <= 200; n++) begin
      @(negedge clk);
      check("busy_during_op", busy, 1);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_timeout", seen, 1);
    if (exp_lat > 0) check("done_latency", n, exp_lat);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("idle_after_done", busy, 0);
    check("all_results_seen", exp_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_row_req"}, row_req, 0);
    check({tag, "_row_addr"}, row_addr, 0);
    check({tag, "_ip_inp1"}, ip_inp1, 0);
    check({tag, "_ip_inp2"}, ip_inp2, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_data"}, res_data, 0);
    check({tag, "_res_idx"}, res_idx, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  always @(negedge clk) begin : monitor
    res_t e;
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("res_idx", res_idx, e.idx);
        check("res_data", res_data, e.data);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [VW-1:0] v, va, vb;
    bit hit;
    rst       = 1'b1;
    start     = 1'b0;
    vec_in    = '0;
    row_valid = 1'b1;
    res_ready = 1'b1;
`ifdef MATVEC_ABORT_EN
    abort     = 1'b0;
`endif
    for (int i = 0; i < 2**AW; i++) mem[i] = '0;

    // Reset state, with start asserted alongside reset.
    repeat (2) @(posedge clk);
    #1 start = 1'b1;
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    start = 1'b0;
    rst   = 1'b0;

    // Basic results.
    mem[0] = pack4(1, 2, 3, 4);
    mem[1] = pack4(16, 16, 16, 16);
    push_exp(0, 20);
    push_exp(1, 128);
    start_op(pack4(2, 2, 2, 2));
    wait_done(7);
    check("basic_vec_reg", ip_inp2, pack4(2, 2, 2, 2));

    // Overflow wrap.
    mem[0] = pack4(255, 255, 255, 255);
    mem[1] = pack4(1, 2, 3, 4);
    push_exp(0, 4);
    push_exp(1, 246);
    start_op(pack4(255, 255, 255, 255));
    wait_done(7);

    // Fetch stall followed by result backpressure.
    mem[0] = VW'($urandom);
    mem[1] = VW'($urandom);
    v      = VW'($urandom);
    push_model(v);
    row_valid = 1'b0;
    res_ready = 1'b0;
    start_op(v);
    for (int i = 0; i < 3; i++) begin
      check("stall_row_req", row_req, 1);
      check("stall_row_addr", row_addr, 0);
      @(posedge clk); #1;
    end
    row_valid = 1'b1;
    hit = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (res_valid) begin
        hit = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("bp_res_valid_timeout", hit, 1);
    for (int i = 0; i < 5; i++) begin
      check("bp_res_valid", res_valid, 1);
      check("bp_res_data", res_data, exp_q[0].data);
      check("bp_res_idx", res_idx, exp_q[0].idx);
      check("bp_no_row_req", row_req, 0);
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    wait_done(0);

    // Start while busy is ignored; the new vector is used on the next start.
    mem[0] = VW'($urandom);
    mem[1] = VW'($urandom);
    va     = VW'($urandom);
    vb     = ~va;
    push_model(va);
    start_op(va);
    @(posedge clk); #1;
    vec_in = vb;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    check("busy_start_vec_kept", ip_inp2, va);
    wait_done(0);
    push_model(vb);
    start_op(vb);
    wait_done(7);
    check("new_vec_used", ip_inp2, vb);

    // Reset in OUT of row 0.
    push_model(vb);
    start_op(vb);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_in_out_state", res_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_all_zero("midrst");
    check("midrst_pending", exp_q.size(), 2);
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      check("midrst_no_done", done, 0);
    end
    v = VW'($urandom);
    push_model(v);
    start_op(v);
    wait_done(7);

`ifdef MATVEC_ABORT_EN
    // Abort in CALC of row 1.
    v = VW'($urandom);
    push_model(v);
    start_op(v);
    repeat (4) begin
      @(posedge clk); #1;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_idle", busy, 0);
    check("abort_row_req", row_req, 0);
    check("abort_res_valid", res_valid, 0);
    check("abort_inp1_kept", ip_inp1, mem[1]);
    check("abort_inp2_kept", ip_inp2, v);
    check("abort_row1_dropped", exp_q.size(), 1);
    repeat (4) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
      check("abort_no_res", res_valid, 0);
    end
    exp_q.delete();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
